multi_cycle_control_unit: RTL and testbench

//  Multi-cycle RV32I control FSM. It sequences IF->ID->EX->[MEM]->[WB] for the multi-cycle datapath.
//  It drives mux selects and register/memory enables per state, and waits on a variable-latency memory.
//  It replaces the single-cycle decoder and sits between the IR opcode field and the datapath.

---
 rtl/multi_cycle_control_unit_pkg.sv | 56 +++++
 rtl/multi_cycle_control_unit_mem_wait_timer.sv | 33 +++
 rtl/multi_cycle_control_unit.sv | 169 ++++++++++++++++
 tb/tb_multi_cycle_control_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared types for the multi-cycle RV32I control unit.
// States, opcodes, mux encodings and the control bundle.
package multi_cycle_control_unit_pkg;

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_ECALL = 3'd5
  } state_t;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_R      = 2'b10;
  localparam logic [1:0] ALU_I      = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       reg_write;
    logic       pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_ecall;
    logic       illegal_inst;
  } ctrl_t;

  function automatic logic is_mem_state(state_t s);
    return (s == S_IF) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/multi_cycle_control_unit_mem_wait_timer.sv
// Memory completion detector: fixed-latency counter or
// pass-through of the memory ready handshake.
module mem_wait_timer #(
  parameter int USE_MEM_HANDSHAKE = 0,
  parameter int MEM_LATENCY       = 1,
  parameter int CNT_WIDTH         = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic mem_ready,
  output logic done
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 2 ** CNT_WIDTH) begin : g_bad_latency
    $error("mem_wait_timer: MEM_LATENCY out of range");
  end

  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(MEM_LATENCY - 1);

  logic [CNT_WIDTH-1:0] cnt;

  assign done = (USE_MEM_HANDSHAKE != 0) ? mem_ready
                                         : (cnt == LAST);

  // Holds at LAST once done so the counter never wraps.
  always_ff @(posedge clk) begin
    if (reset || start) cnt <= '0;
    else if (!done)     cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control FSM: IF, ID, EX, MEM, WB, ECALL.
// Drives datapath enables and mux selects per state.
module multi_cycle_control_unit
  import multi_cycle_control_unit_pkg::*;
#(
  parameter int USE_MEM_HANDSHAKE = 0,
  parameter int MEM_LATENCY       = 1,
  parameter int CNT_WIDTH         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] part_of_inst,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       pc_to_reg,
  output logic       reg_write,
  output logic       pc_source,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       is_ecall,
  output logic       illegal_inst,
  output logic [2:0] cur_state
);

  state_t state, nxt;
  ctrl_t  c;
  logic   mem_done, start;
  logic   op_r, op_i, op_ld, op_st;
  logic   op_br, op_jal, op_jalr, op_sys, legal;

  assign op_r    = part_of_inst == OP_ARITH;
  assign op_i    = part_of_inst == OP_ARITH_IMM;
  assign op_ld   = part_of_inst == OP_LOAD;
  assign op_st   = part_of_inst == OP_STORE;
  assign op_br   = part_of_inst == OP_BRANCH;
  assign op_jal  = part_of_inst == OP_JAL;
  assign op_jalr = part_of_inst == OP_JALR;
  assign op_sys  = part_of_inst == OP_ECALL;
  assign legal   = op_r | op_i | op_ld | op_st |
                   op_br | op_jal | op_jalr | op_sys;

  mem_wait_timer #(
    .USE_MEM_HANDSHAKE(USE_MEM_HANDSHAKE),
    .MEM_LATENCY      (MEM_LATENCY),
    .CNT_WIDTH        (CNT_WIDTH)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mem_ready(mem_ready),
    .done     (mem_done)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      S_IF:    if (mem_done) nxt = S_ID;
      S_ID: begin
        if (op_sys)      nxt = S_ECALL;
        else if (!legal) nxt = S_IF;
        else             nxt = S_EX;
      end
      S_EX: begin
        if (op_r | op_i)        nxt = S_WB;
        else if (op_ld | op_st) nxt = S_MEM;
        else                    nxt = S_IF;
      end
      S_MEM:   if (mem_done) nxt = op_ld ? S_WB : S_IF;
      default: nxt = S_IF;
    endcase
  end

  // Clear the counter on every fresh entry into a memory state.
  assign start = is_mem_state(nxt) &&
                 !(is_mem_state(state) && !mem_done);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IF;
    else       state <= nxt;
  end

  always_comb begin
    c = '0;
    unique case (state)
      S_IF: begin
        c.mem_read  = 1'b1;
        c.alu_src_a = SRC_A_PC;
        c.alu_src_b = SRC_B_FOUR;
        c.alu_op    = ALU_ADD;
        c.ir_write  = mem_done;
        c.pc_write  = mem_done;
      end
      S_ID: begin
        c.alu_src_a    = SRC_A_OLD_PC;
        c.alu_src_b    = SRC_B_IMM;
        c.alu_op       = ALU_ADD;
        c.illegal_inst = !legal;
      end
      S_EX: begin
        unique case (1'b1)
          op_r: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_RS2;
            c.alu_op    = ALU_R;
          end
          op_i: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_I;
          end
          op_ld, op_st: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_ADD;
          end
          op_br: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_RS2;
            c.alu_op    = ALU_BRANCH;
            c.pc_source = 1'b1;
            c.pc_write  = alu_bcond;
          end
          op_jal: begin
            c.pc_write  = 1'b1;
            c.pc_source = 1'b1;
            c.reg_write = 1'b1;
            c.pc_to_reg = 1'b1;
          end
          op_jalr: begin
            c.alu_src_a = SRC_A_RS1;
            c.alu_src_b = SRC_B_IMM;
            c.alu_op    = ALU_ADD;
            c.pc_write  = 1'b1;
            c.reg_write = 1'b1;
            c.pc_to_reg = 1'b1;
          end
          default: c = '0;
        endcase
      end
      S_MEM: begin
        c.i_or_d    = 1'b1;
        c.mem_read  = op_ld;
        c.mem_write = op_st;
      end
      S_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = op_ld;
      end
      S_ECALL: c.is_ecall = 1'b1;
      default: c = '0;
    endcase
    if (reset) c = '0;
  end

  assign {pc_write, i_or_d, mem_read, mem_write, ir_write,
          mem_to_reg, pc_to_reg, reg_write, pc_source,
          alu_src_a, alu_src_b, alu_op,
          is_ecall, illegal_inst} = c;

  assign cur_state = reset ? 3'd0 : state;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench: three configurations (latency 1, latency 3, handshake)
// checked cycle-by-cycle against traces built from the ISA rules.
module tb_multi_cycle_control_unit;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;
  localparam logic [2:0] S_EC  = 3'd5;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       reg_write;
    logic       pc_source;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic       is_ecall;
    logic       illegal;
    logic [2:0] st;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       bc;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  typedef struct {
    int         d;
    logic [6:0] op;
    int         bc;
    int         ifw;
    int         memw;
  } dir_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op_i [3];
  logic       bc_i [3];
  logic       rdy_i[3];
  outs_t      got  [3];

  vec_t       q[3][$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [6:0] ops[8];
  dir_t       dir[12];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       pcw, iod, mr, mw, irw, m2r, p2r, rw, psrc;
    logic [1:0] sa, sb, aop;
    logic       ec, ill;
    logic [2:0] cs;

    multi_cycle_control_unit #(
      .USE_MEM_HANDSHAKE((g == 2) ? 1 : 0),
      .MEM_LATENCY      ((g == 1) ? 3 : 1),
      .CNT_WIDTH        (4)
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .part_of_inst(op_i[g]),
      .alu_bcond   (bc_i[g]),
      .mem_ready   (rdy_i[g]),
      .pc_write    (pcw),
      .i_or_d      (iod),
      .mem_read    (mr),
      .mem_write   (mw),
      .ir_write    (irw),
      .mem_to_reg  (m2r),
      .pc_to_reg   (p2r),
      .reg_write   (rw),
      .pc_source   (psrc),
      .alu_src_a   (sa),
      .alu_src_b   (sb),
      .alu_op      (aop),
      .is_ecall    (ec),
      .illegal_inst(ill),
      .cur_state   (cs)
    );

    assign got[g] = {pcw, iod, mr, mw, irw, m2r, p2r, rw, psrc,
                     sa, sb, aop, ec, ill, cs};
  end

  function automatic bit is_hs(int d);
    return d == 2;
  endfunction

  function automatic int lat_of(int d);
    return (d == 1) ? 3 : 1;
  endfunction

  function automatic bit legal(logic [6:0] o);
    return o == OP_R || o == OP_I || o == OP_LD || o == OP_ST ||
           o == OP_BR || o == OP_JAL || o == OP_JALR ||
           o == OP_SYS;
  endfunction

  function automatic vec_t blank(logic [6:0] o);
    vec_t v;
    v.rst = 1'b0;
    v.op  = o;
    v.bc  = 1'($urandom);
    v.rdy = 1'($urandom);
    v.exp = '0;
    return v;
  endfunction

  // Cycles spent in one memory access for configuration d.
  function automatic int acc_len(int d, int w);
    if (!is_hs(d)) return lat_of(d);
    return ((w < 0) ? int'($urandom_range(0, 3)) : w) + 1;
  endfunction

  task automatic gen_instr(int d, logic [6:0] o, int bc,
                           int ifw, int memw);
    vec_t v;
    int   n;
    bit   ld = (o == OP_LD);
    n = acc_len(d, ifw);
    for (int i = 0; i < n; i++) begin
      v = blank(7'($urandom));
      v.exp.st       = S_IF;
      v.exp.mem_read = 1'b1;
      v.exp.b        = 2'b01;
      v.exp.ir_write = (i == n - 1);
      v.exp.pc_write = (i == n - 1);
      if (is_hs(d)) v.rdy = (i == n - 1);
      q[d].push_back(v);
    end
    v = blank(o);
    v.exp.st      = S_ID;
    v.exp.a       = 2'b01;
    v.exp.b       = 2'b10;
    v.exp.illegal = !legal(o);
    q[d].push_back(v);
    if (!legal(o)) return;
    if (o == OP_SYS) begin
      v = blank(o);
      v.exp.st       = S_EC;
      v.exp.is_ecall = 1'b1;
      q[d].push_back(v);
      return;
    end
    v = blank(o);
    v.exp.st = S_EX;
    case (o)
      OP_R: begin
        v.exp.a = 2'b10; v.exp.op = 2'b10;
      end
      OP_I: begin
        v.exp.a = 2'b10; v.exp.b = 2'b10; v.exp.op = 2'b11;
      end
      OP_LD, OP_ST: begin
        v.exp.a = 2'b10; v.exp.b = 2'b10;
      end
      OP_BR: begin
        if (bc >= 0) v.bc = bc[0];
        v.exp.a         = 2'b10;
        v.exp.op        = 2'b01;
        v.exp.pc_source = 1'b1;
        v.exp.pc_write  = v.bc;
      end
      OP_JAL: begin
        v.exp.pc_write  = 1'b1;
        v.exp.pc_source = 1'b1;
        v.exp.reg_write = 1'b1;
        v.exp.pc_to_reg = 1'b1;
      end
      default: begin
        v.exp.a         = 2'b10;
        v.exp.b         = 2'b10;
        v.exp.pc_write  = 1'b1;
        v.exp.reg_write = 1'b1;
        v.exp.pc_to_reg = 1'b1;
      end
    endcase
    q[d].push_back(v);
    if (o == OP_LD || o == OP_ST) begin
      n = acc_len(d, memw);
      for (int i = 0; i < n; i++) begin
        v = blank(o);
        v.exp.st        = S_MEM;
        v.exp.i_or_d    = 1'b1;
        v.exp.mem_read  = ld;
        v.exp.mem_write = !ld;
        if (is_hs(d)) v.rdy = (i == n - 1);
        q[d].push_back(v);
      end
    end
    if (o == OP_R || o == OP_I || ld) begin
      v = blank(o);
      v.exp.st         = S_WB;
      v.exp.reg_write  = 1'b1;
      v.exp.mem_to_reg = ld;
      q[d].push_back(v);
    end
  endtask

  task automatic gen_random(int d);
    logic [6:0] o;
    int r = $urandom_range(0, 9);
    o = (r < 8) ? ops[r] : 7'($urandom);
    gen_instr(d, o, -1, -1, -1);
  endtask

  task automatic do_reset(int n);
    vec_t v;
    for (int d = 0; d < 3; d++) begin
      q[d].delete();
      for (int i = 0; i < n; i++) begin
        v     = blank(7'($urandom));
        v.rst = 1'b1;
        q[d].push_back(v);
      end
    end
  endtask

  task automatic step();
    vec_t v[3];
    for (int d = 0; d < 3; d++)
      if (q[d].size() == 0) gen_random(d);
    for (int d = 0; d < 3; d++) v[d] = q[d].pop_front();
    reset = v[0].rst;
    for (int d = 0; d < 3; d++) begin
      op_i[d]  = v[d].op;
      bc_i[d]  = v[d].bc;
      rdy_i[d] = v[d].rdy;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (got[d] !== v[d].exp) begin
        bad++;
        $display("FAIL outs cyc=%0d dut%0d got=%b want=%b",
                 cyc, d, got[d], v[d].exp);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_SYS};
    dir[0]  = '{0, OP_R,    -1, -1, -1};
    dir[1]  = '{1, OP_LD,   -1, -1, -1};
    dir[2]  = '{0, OP_BR,    0, -1, -1};
    dir[3]  = '{0, OP_BR,    1, -1, -1};
    dir[4]  = '{2, OP_SYS,  -1,  0, -1};
    dir[5]  = '{2, 7'h00,   -1,  2, -1};
    dir[6]  = '{1, OP_ST,   -1, -1, -1};
    dir[7]  = '{1, OP_JAL,  -1, -1, -1};
    dir[8]  = '{1, OP_JALR, -1, -1, -1};
    dir[9]  = '{2, OP_LD,   -1,  3,  2};
    dir[10] = '{0, OP_I,    -1, -1, -1};
    dir[11] = '{1, OP_BR,    1, -1, -1};
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      op_i[d] = '0; bc_i[d] = 1'b0; rdy_i[d] = 1'b0;
    end
    @(posedge clk);
    #1;
    do_reset(2);
    step();
    step();
    for (int k = 0; k < 12; k++) begin
      while (q[dir[k].d].size() != 0) step();
      gen_instr(dir[k].d, dir[k].op, dir[k].bc,
                dir[k].ifw, dir[k].memw);
    end
    // Store stalled on the handshake, reset lands mid-wait.
    while (q[2].size() != 0) step();
    gen_instr(2, OP_ST, -1, 0, 5);
    repeat (5) step();
    do_reset(2);
    repeat (8) step();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0)
        do_reset($urandom_range(1, 2));
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
